// File: rtl/lcd_driver_window_if.sv
// Bundles the configuration port and the panel/pixel-request port of lcd_driver_window.
// The master side is the timing generator; the slave side is the system (config + frame buffer).
interface lcd_driver_window_if #(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned COORD_W = 11
);
    logic [COORD_W-1:0] cfg_x_start;
    logic [COORD_W-1:0] cfg_y_start;
    logic [COORD_W-1:0] cfg_x_size;
    logic [COORD_W-1:0] cfg_y_size;
    logic [DATA_W-1:0]  cfg_bg_color;
    logic               cfg_update;
    logic               cfg_pending;
    logic               lcd_dclk;
    logic               lcd_hs;
    logic               lcd_vs;
    logic               lcd_de;
    logic               lcd_blank;
    logic [DATA_W-1:0]  lcd_rgb;
    logic               lcd_request;
    logic [COORD_W-1:0] lcd_xpos;
    logic [COORD_W-1:0] lcd_ypos;
    logic [DATA_W-1:0]  lcd_data;
    logic               frame_start;
    logic               line_start;

    modport master (
        input  cfg_x_start, cfg_y_start, cfg_x_size, cfg_y_size, cfg_bg_color, cfg_update,
        input  lcd_data,
        output cfg_pending, lcd_dclk, lcd_hs, lcd_vs, lcd_de, lcd_blank, lcd_rgb,
        output lcd_request, lcd_xpos, lcd_ypos, frame_start, line_start
    );

    modport slave (
        output cfg_x_start, cfg_y_start, cfg_x_size, cfg_y_size, cfg_bg_color, cfg_update,
        output lcd_data,
        input  cfg_pending, lcd_dclk, lcd_hs, lcd_vs, lcd_de, lcd_blank, lcd_rgb,
        input  lcd_request, lcd_xpos, lcd_ypos, frame_start, line_start
    );
endinterface

// File: rtl/lcd_driver_window.sv
// RGB LCD timing generator with a double-buffered display window. Pixel requests lead the
// display by REQ_AHEAD cycles; active pixels outside the window show the background colour.
module lcd_driver_window #(
    parameter int unsigned H_SYNC      = 128,
    parameter int unsigned H_BACK      = 88,
    parameter int unsigned H_DISP      = 1024,
    parameter int unsigned H_FRONT     = 40,
    parameter int unsigned V_SYNC      = 4,
    parameter int unsigned V_BACK      = 23,
    parameter int unsigned V_DISP      = 600,
    parameter int unsigned V_FRONT     = 1,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned REQ_AHEAD   = 1,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter int unsigned X_START_RST = 192,
    parameter int unsigned Y_START_RST = 60,
    parameter int unsigned X_SIZE_RST  = 640,
    parameter int unsigned Y_SIZE_RST  = 480
) (
    input logic                 clk,
    input logic                 rst_n,
    lcd_driver_window_if.master bus
);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HA      = H_SYNC + H_BACK;
    localparam int unsigned VA      = V_SYNC + V_BACK;

    localparam coord_t HLast   = coord_t'(H_TOTAL - 1);
    localparam coord_t VLast   = coord_t'(V_TOTAL - 1);
    localparam coord_t HSyncC  = coord_t'(H_SYNC);
    localparam coord_t VSyncC  = coord_t'(V_SYNC);
    localparam coord_t HaC     = coord_t'(HA);
    localparam coord_t HaEndC  = coord_t'(HA + H_DISP);
    localparam coord_t VaC     = coord_t'(VA);
    localparam coord_t VaEndC  = coord_t'(VA + V_DISP);
    localparam wide_t  HaW     = wide_t'(HA);
    localparam wide_t  VaW     = wide_t'(VA);
    localparam wide_t  HDispW  = wide_t'(H_DISP);
    localparam wide_t  VDispW  = wide_t'(V_DISP);
    localparam wide_t  ReqW    = wide_t'(REQ_AHEAD);

    coord_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic   frame_end, apply;

    coord_t act_xs_q, act_ys_q, act_xw_q, act_yh_q;
    coord_t pnd_xs_q, pnd_ys_q, pnd_xw_q, pnd_yh_q;
    coord_t xs_d, ys_d, xw_d, yh_d;
    logic   pending_q;

    logic   hs_q, vs_q, de_q, blank_q, fstart_q, lstart_q;
    logic   req_q, req_d;
    coord_t xpos_q, xpos_d, ypos_q, ypos_d;
    logic   win_dly;

    wide_t  x_sum, x_end, y_sum, y_end, h_pos, v_pos;
    logic   h_hit, v_hit;

    // Next counter values and the window set that will be live once they are reached.
    always_comb begin
        frame_end = (hcnt_q == HLast) && (vcnt_q == VLast);
        hcnt_d    = hcnt_q + coord_t'(1);
        vcnt_d    = vcnt_q;
        if (hcnt_q == HLast) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + coord_t'(1);
        end
        apply = frame_end && pending_q;
        xs_d  = apply ? pnd_xs_q : act_xs_q;
        ys_d  = apply ? pnd_ys_q : act_ys_q;
        xw_d  = apply ? pnd_xw_q : act_xw_q;
        yh_d  = apply ? pnd_yh_q : act_yh_q;
    end

    // Window hit test for the position REQ_AHEAD cycles ahead; one extra bit so nothing wraps.
    always_comb begin
        x_sum  = {1'b0, xs_d} + {1'b0, xw_d};
        x_end  = (x_sum > HDispW) ? HDispW : x_sum;
        y_sum  = {1'b0, ys_d} + {1'b0, yh_d};
        y_end  = (y_sum > VDispW) ? VDispW : y_sum;
        h_pos  = {1'b0, hcnt_d} + ReqW;
        v_pos  = {1'b0, vcnt_d};
        h_hit  = (h_pos >= HaW) && ((h_pos - HaW) >= {1'b0, xs_d}) && ((h_pos - HaW) < x_end);
        v_hit  = (v_pos >= VaW) && ((v_pos - VaW) >= {1'b0, ys_d}) && ((v_pos - VaW) < y_end);
        req_d  = h_hit && v_hit;
        xpos_d = '0;
        ypos_d = '0;
        if (req_d) begin
            xpos_d = coord_t'(h_pos - HaW - {1'b0, xs_d});
            ypos_d = coord_t'(v_pos - VaW - {1'b0, ys_d});
        end
    end

    // Counters and registered timing outputs, decoded from the next counter values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hs_q     <= HS_POL;
            vs_q     <= VS_POL;
            de_q     <= 1'b0;
            blank_q  <= 1'b0;
            fstart_q <= 1'b0;
            lstart_q <= 1'b0;
            req_q    <= 1'b0;
            xpos_q   <= '0;
            ypos_q   <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hs_q     <= (hcnt_d < HSyncC) ? HS_POL : ~HS_POL;
            vs_q     <= (vcnt_d < VSyncC) ? VS_POL : ~VS_POL;
            de_q     <= (hcnt_d >= HaC) && (hcnt_d < HaEndC) && (vcnt_d >= VaC) &&
                        (vcnt_d < VaEndC);
            blank_q  <= !((hcnt_d < HSyncC) || (vcnt_d < VSyncC));
            fstart_q <= (hcnt_d == '0) && (vcnt_d == '0);
            lstart_q <= (hcnt_d == '0);
            req_q    <= req_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
        end
    end

    // Pending/active window sets; the pending set is promoted only at the frame-end cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_xs_q  <= coord_t'(X_START_RST);
            act_ys_q  <= coord_t'(Y_START_RST);
            act_xw_q  <= coord_t'(X_SIZE_RST);
            act_yh_q  <= coord_t'(Y_SIZE_RST);
            pnd_xs_q  <= coord_t'(X_START_RST);
            pnd_ys_q  <= coord_t'(Y_START_RST);
            pnd_xw_q  <= coord_t'(X_SIZE_RST);
            pnd_yh_q  <= coord_t'(Y_SIZE_RST);
            pending_q <= 1'b0;
        end else begin
            act_xs_q <= xs_d;
            act_ys_q <= ys_d;
            act_xw_q <= xw_d;
            act_yh_q <= yh_d;
            if (bus.cfg_update) begin
                pnd_xs_q  <= bus.cfg_x_start;
                pnd_ys_q  <= bus.cfg_y_start;
                pnd_xw_q  <= bus.cfg_x_size;
                pnd_yh_q  <= bus.cfg_y_size;
                pending_q <= 1'b1;
            end else if (frame_end) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Align the window flag with the returned pixel data.
    if (REQ_AHEAD == 0) begin : g_dly
        assign win_dly = req_q;
    end else begin : g_dly
        logic [REQ_AHEAD-1:0] dly_q;
        // Shift the request flag along with the frame-buffer latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= req_q;
                for (int i = 1; i < int'(REQ_AHEAD); i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
        assign win_dly = dly_q[REQ_AHEAD-1];
    end

    assign bus.cfg_pending = pending_q;
    assign bus.lcd_dclk    = clk;
    assign bus.lcd_hs      = hs_q;
    assign bus.lcd_vs      = vs_q;
    assign bus.lcd_de      = de_q;
    assign bus.lcd_blank   = blank_q;
    assign bus.lcd_request = req_q;
    assign bus.lcd_xpos    = xpos_q;
    assign bus.lcd_ypos    = ypos_q;
    assign bus.frame_start = fstart_q;
    assign bus.line_start  = lstart_q;
    // Pixel data is passed straight through so it lines up with the request latency.
    assign bus.lcd_rgb     = !de_q   ? {DATA_W{1'b0}} :
                             win_dly ? bus.lcd_data   : bus.cfg_bg_color;

endmodule
